// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, division opcodes and the divide sequencer state encoding.
package alu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] OP_DIV  = 5'b01100;
    localparam logic [OP_W-1:0] OP_DIVU = 5'b01101;
    localparam logic [OP_W-1:0] OP_REM  = 5'b01110;
    localparam logic [OP_W-1:0] OP_REMU = 5'b01111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ITER   = 2'd2,
        FINISH = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
module div_step
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] rem_in,
    input  logic            dvd_msb,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out_c,
    output logic            q_bit_c
);

    logic [XLEN:0] shifted;

    // Shifted partial remainder can reach XLEN+1 bits before the trial subtract.
    assign shifted   = {rem_in, dvd_msb};
    assign q_bit_c   = (shifted >= {1'b0, divisor});
    assign rem_out_c = q_bit_c ? XLEN'(shifted - {1'b0, divisor}) : shifted[XLEN-1:0];

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divide/remainder sequencer for the EX stage, with fast path for
// divide-by-zero and signed overflow; stalls the pipeline while an operation runs.
module div_sequencer #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OP_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [OP_W-1:0] opcode,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    import alu_pkg::*;

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t       state_q, state_nx;
    logic             busy_nx, done_nx;
    logic [XLEN-1:0]  result_nx;
    logic             signed_op, signed_op_nx;
    logic             rem_op, rem_op_nx;
    logic             q_neg, q_neg_nx;
    logic             r_neg, r_neg_nx;
    logic [XLEN-1:0]  op_a, op_a_nx;
    logic [XLEN-1:0]  op_b, op_b_nx;
    logic [XLEN-1:0]  dq, dq_nx;
    logic [XLEN-1:0]  rem, rem_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    logic             is_div, accept;
    logic             sign_a, sign_b;
    logic [XLEN-1:0]  abs_a, abs_b;
    logic [XLEN-1:0]  step_rem;
    logic             step_q;

    assign is_div = (opcode == OP_W'(OP_DIV))  || (opcode == OP_W'(OP_DIVU)) ||
                    (opcode == OP_W'(OP_REM))  || (opcode == OP_W'(OP_REMU));
    assign accept = start && is_div && (state_q == IDLE) && !done && !flush;
    assign stall  = busy || (start && is_div && !done);

    assign sign_a = signed_op && op_a[XLEN-1];
    assign sign_b = signed_op && op_b[XLEN-1];
    assign abs_a  = sign_a ? -op_a : op_a;
    assign abs_b  = sign_b ? -op_b : op_b;

    // dq starts as the dividend magnitude and fills with quotient bits from the LSB.
    div_step u_step (
        .rem_in    (rem),
        .dvd_msb   (dq[XLEN-1]),
        .divisor   (op_b),
        .rem_out_c (step_rem),
        .q_bit_c   (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            signed_op <= 1'b0;
            rem_op    <= 1'b0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            dq        <= '0;
            rem       <= '0;
            cnt       <= '0;
        end else begin
            state_q   <= state_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            result    <= result_nx;
            signed_op <= signed_op_nx;
            rem_op    <= rem_op_nx;
            q_neg     <= q_neg_nx;
            r_neg     <= r_neg_nx;
            op_a      <= op_a_nx;
            op_b      <= op_b_nx;
            dq        <= dq_nx;
            rem       <= rem_nx;
            cnt       <= cnt_nx;
        end
    end

    always_comb begin
        state_nx     = state_q;
        busy_nx      = busy;
        done_nx      = 1'b0;
        result_nx    = result;
        signed_op_nx = signed_op;
        rem_op_nx    = rem_op;
        q_neg_nx     = q_neg;
        r_neg_nx     = r_neg;
        op_a_nx      = op_a;
        op_b_nx      = op_b;
        dq_nx        = dq;
        rem_nx       = rem;
        cnt_nx       = cnt;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_nx     = SETUP;
                    busy_nx      = 1'b1;
                    op_a_nx      = data1;
                    op_b_nx      = data2;
                    signed_op_nx = (opcode == OP_W'(OP_DIV)) || (opcode == OP_W'(OP_REM));
                    rem_op_nx    = (opcode == OP_W'(OP_REM)) || (opcode == OP_W'(OP_REMU));
                end
            end
            SETUP: begin
                q_neg_nx = sign_a ^ sign_b;
                r_neg_nx = sign_a;
                op_b_nx  = abs_b;
                dq_nx    = abs_a;
                rem_nx   = '0;
                cnt_nx   = '0;
                state_nx = ITER;
                // Special cases preload the final quotient/remainder with signs already applied.
                if (op_b == '0) begin
                    dq_nx    = '1;
                    rem_nx   = op_a;
                    q_neg_nx = 1'b0;
                    r_neg_nx = 1'b0;
                    state_nx = FINISH;
                end else if (signed_op && (op_a == INT_MIN) && (op_b == '1)) begin
                    dq_nx    = INT_MIN;
                    rem_nx   = '0;
                    q_neg_nx = 1'b0;
                    r_neg_nx = 1'b0;
                    state_nx = FINISH;
                end
            end
            ITER: begin
                dq_nx  = {dq[XLEN-2:0], step_q};
                rem_nx = step_rem;
                cnt_nx = cnt + CNT_W'(1);
                if (cnt == CNT_W'(XLEN-1)) begin
                    state_nx = FINISH;
                end
            end
            FINISH: begin
                result_nx = rem_op ? (r_neg ? -rem : rem) : (q_neg ? -dq : dq);
                done_nx   = 1'b1;
                busy_nx   = 1'b0;
                state_nx  = IDLE;
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase

        // Abort wins over completion: no done, result keeps its last value.
        if (flush && (state_q != IDLE)) begin
            state_nx  = IDLE;
            busy_nx   = 1'b0;
            done_nx   = 1'b0;
            result_nx = result;
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: cycle-level reference model plus literal expectations.
module tb_div_sequencer;

    localparam logic [4:0] DIV  = 5'b01100;
    localparam logic [4:0] DIVU = 5'b01101;
    localparam logic [4:0] REM  = 5'b01110;
    localparam logic [4:0] REMU = 5'b01111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  opcode = '0;
    logic [31:0] data1 = '0;
    logic [31:0] data2 = '0;
    logic        stall, busy, done;
    logic [31:0] result;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    div_sequencer #(.XLEN(32), .OP_W(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .opcode (opcode),
        .data1  (data1),
        .data2  (data2),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_div_op(input logic [4:0] op);
        return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
    endfunction

    function automatic bit is_ovf(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        return ((op == DIV) || (op == REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    endfunction

    // RISC-V division semantics from plain integer arithmetic.
    function automatic logic [31:0] ref_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 32'd0) return ((op == REM) || (op == REMU)) ? a : 32'hFFFF_FFFF;
        if (is_ovf(op, a, b)) return (op == DIV) ? 32'h8000_0000 : 32'd0;
        case (op)
            DIV:     return 32'(sa / sb);
            REM:     return 32'(sa % sb);
            DIVU:    return a / b;
            REMU:    return a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Countdown model: 34 edges after accept for the iterative path, 2 for special cases.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_result = '0;
    logic [31:0] m_pending = '0;
    int          m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_result <= '0;
            m_left   <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (flush) begin
                    m_busy <= 1'b0;
                end else if (m_left == 1) begin
                    m_busy   <= 1'b0;
                    m_done   <= 1'b1;
                    m_result <= m_pending;
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (start && is_div_op(opcode) && !m_done && !flush) begin
                m_busy    <= 1'b1;
                m_left    <= ((data2 == 32'd0) || is_ovf(opcode, data1, data2)) ? 2 : 34;
                m_pending <= ref_div(opcode, data1, data2);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy",   32'(busy),   32'(m_busy));
            chk("cyc_done",   32'(done),   32'(m_done));
            chk("cyc_result", result,      m_result);
            chk("cyc_stall",  32'(stall),  32'(m_busy | (start & is_div_op(opcode) & ~m_done)));
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat, input bit hold);
        int n;
        @(posedge clk);
        #1;
        start = 1'b1; opcode = op; data1 = a; data2 = b;
        #1;
        chk({name, "_stall_start"}, 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        wait_done(n);
        chk({name, "_latency"}, 32'(n), 32'(lat));
        chk({name, "_result"}, result, exp);
        if (hold) begin
            chk({name, "_stall_done"}, 32'(stall), 32'd0);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    task automatic count_dones(input int cycles, output int nd);
        nd = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) nd++;
        end
    endtask

    initial begin
        int n, nd;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   32'(busy),  32'd0);
        chk("rst_done",   32'(done),  32'd0);
        chk("rst_result", result,     32'd0);
        chk("rst_stall",  32'(stall), 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        chk("model_divu", ref_div(DIVU, 32'd100, 32'd7), 32'd14);
        chk("model_rem",  ref_div(REM, 32'hFFFF_FF9C, 32'd7), 32'hFFFF_FFFE);
        chk("model_remz", ref_div(REM, 32'd5, 32'd0), 32'd5);

        run_op("divu_100_7",  DIVU, 32'd100,       32'd7,         32'd14,        34, 1'b0);
        run_op("remu_100_7",  REMU, 32'd100,       32'd7,         32'd2,         34, 1'b0);
        run_op("div_m100_7",  DIV,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 34, 1'b0);
        run_op("rem_m100_7",  REM,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 34, 1'b0);
        run_op("div_100_m7",  DIV,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 34, 1'b0);
        run_op("div_m100_m7", DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        34, 1'b0);
        run_op("divu_max_2",  DIVU, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 34, 1'b0);
        run_op("div_5_0",     DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 2,  1'b0);
        run_op("divu_5_0",    DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 2,  1'b0);
        run_op("rem_5_0",     REM,  32'd5,         32'd0,         32'd5,         2,  1'b0);
        run_op("remu_min_0",  REMU, 32'h8000_0000, 32'd0,         32'h8000_0000, 2,  1'b0);
        run_op("div_ovf",     DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2,  1'b0);
        run_op("rem_ovf",     REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2,  1'b0);

        // Held start: one done pulse only.
        run_op("hold_divu", DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b1);
        count_dones(5, nd);
        chk("hold_extra_done", 32'(nd), 32'd0);

        // New start while busy must not disturb the latched operands.
        @(posedge clk);
        #1;
        start = 1'b1; opcode = DIVU; data1 = 32'd100; data2 = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; opcode = DIV; data1 = 32'd1234; data2 = 32'd5;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        chk("busy_start_latency", 32'(n + 7), 32'd34);
        chk("busy_start_result", result, 32'd14);

        // Flush in ITER step 10 after a known result.
        run_op("pre_flush", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b1; opcode = DIVU; data1 = 32'd100; data2 = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        count_dones(40, nd);
        chk("flush_no_done", 32'(nd), 32'd0);
        chk("flush_result_held", result, 32'hFFFF_FFFF);

        // Reset pulse mid-ITER.
        run_op("pre_reset", REMU, 32'd100, 32'd7, 32'd2, 34, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b1; opcode = DIVU; data1 = 32'd100; data2 = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",   32'(busy), 32'd0);
        chk("midrst_done",   32'(done), 32'd0);
        chk("midrst_result", result,    32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_dones(40, nd);
        chk("midrst_no_done", 32'(nd), 32'd0);

        // Flush coincident with a would-be accept.
        @(posedge clk);
        #1;
        start = 1'b1; flush = 1'b1; opcode = DIVU; data1 = 32'd9; data2 = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_accept_busy", 32'(busy), 32'd0);

        // Non-division opcode is ignored.
        @(posedge clk);
        #1;
        start = 1'b1; opcode = 5'b00000; data1 = 32'd9; data2 = 32'd3;
        #1;
        chk("nondiv_stall", 32'(stall), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("nondiv_busy", 32'(busy), 32'd0);
        start = 1'b0;

        run_op("final_divu", DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 34, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle sequencer for the RV32M division opcodes (DIV, DIVU, REM, REMU) in the EX stage. The combinational ALU keeps add, logic, shift, multiply and SLT. This block owns division: it accepts a request, runs a 32-step radix-2 restoring divide, and resolves the RISC-V divide-by-zero and signed-overflow cases in a fast path. It stalls the pipeline until the result is ready.

## Interface
Parameters:
- XLEN, 32, operand and result width; only 32 is supported.
- OP_W, 5, ALU opcode width.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  EX stage presents an instruction this cycle.
- opcode  in  OP_W  ALU opcode: 5'b01100 DIV, 5'b01101 DIVU, 5'b01110 REM, 5'b01111 REMU. Other values are not division ops.
- data1  in  XLEN  dividend.
- data2  in  XLEN  divisor.
- flush  in  1  abort the in-flight operation (branch mispredict or trap).
- stall  out  1  combinational; freezes IF, ID and EX.
- busy  out  1  registered; high while an operation is in flight.
- done  out  1  registered; one-cycle pulse, result valid.
- result  out  XLEN  registered quotient or remainder; holds until the next done.

## Operation
- is_div = opcode in 01100..01111.
- accept = start & is_div & (state==IDLE) & ~done & ~flush.
- On accept, latch data1, data2, opcode; derive signed_op (DIV/REM) and rem_op (REM/REMU).
- States:
  - IDLE: waits for accept, then goes to SETUP.
  - SETUP: for signed_op, take absolute values and record q_neg = sign1^sign2 and r_neg = sign1. Detect special cases; a special case goes to FINISH with the result preloaded, otherwise go to ITER with the step counter at 0.
  - ITER: 32 cycles. Each cycle shifts the remainder left with the next dividend MSB, trial-subtracts the divisor, and sets the quotient bit if the subtraction does not underflow. After counter 31, go to FINISH.
  - FINISH: apply signs (quotient negated if q_neg, remainder negated if r_neg). Load result with the quotient or remainder, pulse done, return to IDLE.
- Special cases (RISC-V spec):
  - divisor 0: DIV and DIVU give 0xFFFFFFFF; REM and REMU give data1.
  - DIV/REM with 0x80000000 and -1: DIV gives 0x80000000, REM gives 0.
- stall = busy | (start & is_div & ~done).
- flush has priority over everything. Any non-IDLE state goes to IDLE at the next edge; done and result are not updated. A flush in the same cycle as a would-be accept blocks the accept.
- start with a non-div opcode is ignored: no stall, state unchanged.
- start while busy is ignored; the latched operands are not overwritten.

## Timing
- Reset values: state IDLE; busy 0; done 0; result 0; internal registers 0. stall follows from those inputs.
- Accept at edge E0; SETUP runs in cycle E0→E1.
- Normal path:
  - ITER runs E1..E33; FINISH runs E33→E34.
  - done=1 and result valid in cycle E34→E35, so latency is 34 edges.
  - busy is high from after E0 until E34.
- Special path: FINISH runs E1→E2; done is high after E2, so latency is 2.
- In the done cycle, stall=0 and the pipeline advances on the next edge. The held start is not re-accepted because of ~done.
- Back-to-back operations need one done cycle between them; the minimum issue interval is 35 cycles on the normal path.
- rst_n asserted mid-operation clears everything immediately; no done is produced.

## Structure
- Shared package (alu_pkg, also used by alu): opcode constants OP_DIV, OP_DIVU, OP_REM, OP_REMU; XLEN; state enum div_state_t {IDLE, SETUP, ITER, FINISH}.
- One sub-module: div_step, a combinational single restoring-division step. Inputs are remainder, dividend MSB and divisor; outputs are the new remainder and the quotient bit. It is instantiated once inside the ITER datapath.

## Test plan
- DIVU 100/7 → done after 34 cycles, result 14. REMU 100/7 → result 2. stall is high from the start cycle until done.
- DIV 0xFFFFFF9C(-100)/7 → 0xFFFFFFF2. REM with the same operands → 0xFFFFFFFE. DIV 100/0xFFFFFFF9 → 0xFFFFFFF2.
- Divide by zero, latency 2:
  - DIV 5/0 → 0xFFFFFFFF; DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5; REMU 0x80000000/0 → 0x80000000.
- Overflow, latency 2: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- flush at ITER cycle 10 → busy is 0 next cycle, no done, result keeps its previous value. start held high through done → exactly one done pulse. A new start during busy is ignored.
- rst_n low for one cycle mid-ITER → busy, done and result become 0 immediately. Opcode 5'b00000 with start=1 → stall stays 0 and busy stays 0.
